input_output: RTL and testbench
===============================

Name: input_output

Overview:
- Single-pulse generator for user inputs such as push-buttons or keys.
- Each input channel produces exactly one clock-wide high pulse on its output when the channel goes from low to high (a "press").
- Holding the input high produces no further pulses; a new pulse requires release then re-press.
- Sits between raw input pins (optionally synchronised here) and downstream control logic that consumes one event per press.

Parameters:
- WIDTH, 1, number of independent input channels; in/out are WIDTH bits.
- SYNC_STAGES, 0, flip-flop synchroniser stages inserted on each input before the detector. Legal values are 0..4. At 0 the input is sampled directly.

Ports:
- clk  input  1  single system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset. reset=0 forces reset state immediately, independent of clk.
- in  input  WIDTH  raw level inputs, 1 = pressed.
- out  output  WIDTH  registered one-cycle pulse per channel, 1 = press event.

Behaviour:
- Reset (reset=0, asynchronous):
  - out = 0 for all bits.
  - Every channel state = NOT_PRESSED.
  - All synchroniser flops = 0.
  - Release is sampled on the next posedge clk.
- Per-channel FSM, two states, clocked on posedge clk. s = synchronised input bit, which equals in[i] when SYNC_STAGES=0.
  - NOT_PRESSED, s=0: stay NOT_PRESSED, next out[i]=0.
  - NOT_PRESSED, s=1: go to PRESSED, next out[i]=1.
  - PRESSED, s=1: stay PRESSED, next out[i]=0.
  - PRESSED, s=0: go to NOT_PRESSED, next out[i]=0.
- out is a registered (flop) output, not combinational.
- Latency: with SYNC_STAGES=0, out[i] rises on the same posedge that first samples in[i]=1. In general, latency from the first sampling edge = SYNC_STAGES clock cycles.
- Pulse width: exactly 1 clock cycle, regardless of how long in stays high.
- A 1-cycle high input (0,1,0) yields one 1-cycle pulse. Alternating 1,0,1,0 yields a pulse on every high cycle.
- Input high while reset is asserted and still high after release: treated as a new press, giving one pulse on the first sampling edge after release (plus sync latency).
- Reset asserted mid-pulse: out clears to 0 immediately and the pending pulse is lost.
- Channels are fully independent. Simultaneous presses on several bits give simultaneous pulses.
- No glitch on out between clock edges. Unknown input during reset has no effect on out.

Decomposition:
- Shared package holds:
  - enum state_t {NOT_PRESSED, PRESSED}.
  - localparam MAX_SYNC_STAGES = 4.
- Natural sub-module: input_output_cell, a one-channel synchroniser plus FSM plus output flop, parameterised by SYNC_STAGES.
- The top level is a generate loop over WIDTH instances of input_output_cell.

Test Plan:
- Reset and idle: reset=0 for 2 cycles with in=0, release, hold in=0 for 4 cycles -> out=0 throughout. Assert reset=0 between edges -> out=0 with no clock edge needed.
- Press and hold (WIDTH=1, SYNC_STAGES=0): in=0 for 4 cycles, then in=1 for 4 cycles -> out=1 on exactly the first edge sampling in=1, then 0 for the remaining 3 cycles.
- Release and re-press: continue with in=0 for 4 cycles, then in=1 for 4 cycles -> out=0 during release and exactly one 1-cycle pulse at re-press (sequence 0,0,0,0,1,0,0,0).
- Short and toggling inputs: in pattern 1,0,1,0,1 on consecutive edges -> out 1,0,1,0,1. A single-cycle in=1 gives a single pulse.
- Reset interactions: hold in=1 through reset and release -> one pulse on the first edge after release. Assert reset while out=1 -> out=0 immediately and no pulse after re-release if in=0.
- Multi-channel and sync (WIDTH=4, SYNC_STAGES=2): in=4'b0101 then 4'b1111 -> out=4'b0101 pulse 2 cycles after first sampling. Next, out=4'b1010 pulse one cycle after that transition plus the same 2-cycle latency. Each pulse is 1 cycle wide.

Source files
------------

// File: rtl/input_output_pkg.sv
// Shared types and limits for the single-pulse press detector.
`default_nettype none

package input_output_pkg;

   typedef enum logic {
      NOT_PRESSED = 1'b0,
      PRESSED     = 1'b1
   } state_t;

   localparam int MAX_SYNC_STAGES = 4;

endpackage

`default_nettype wire

// File: rtl/input_output_cell.sv
// One channel: optional synchroniser chain, press FSM and registered pulse output.
`default_nettype none

module input_output_cell
   import input_output_pkg::*;
#(
   parameter int SYNC_STAGES = 0
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic out
);

   // Out-of-range stage counts are clamped rather than producing a broken chain.
   localparam int STAGES = (SYNC_STAGES > MAX_SYNC_STAGES) ? MAX_SYNC_STAGES :
                           (SYNC_STAGES < 0) ? 0 : SYNC_STAGES;

   logic   s;
   state_t state;

   generate
      if (STAGES == 0) begin : g_nosync
         assign s = in;
      end else begin : g_sync
         logic [STAGES-1:0] sync_q;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               sync_q <= '0;
            end else begin
               sync_q[0] <= in;
               for (int k = 1; k < STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign s = sync_q[STAGES-1];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= NOT_PRESSED;
         out   <= 1'b0;
      end else begin
         case (state)
            NOT_PRESSED: begin
               out <= s;
               if (s) begin
                  state <= PRESSED;
               end
            end
            PRESSED: begin
               out <= 1'b0;
               if (!s) begin
                  state <= NOT_PRESSED;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/input_output.sv
// Multi-channel single-pulse generator: one independent press detector per input bit.
`default_nettype none

module input_output
   import input_output_pkg::*;
#(
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_cell
         input_output_cell #(
            .SYNC_STAGES (SYNC_STAGES)
         ) u_cell (
            .clk   (clk),
            .reset (reset),
            .in    (in[i]),
            .out   (out[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_input_output.sv
// Directed plus random checks of two configurations against a press-history model.
`default_nettype none

module tb_input_output;

   logic       clk;
   logic       reset;
   logic [0:0] in1;
   logic [0:0] out1;
   logic [3:0] in4;
   logic [3:0] out4;

   int vectors;
   int miscompares;

   // Input vectors sampled on each active edge since the last reset.
   logic [3:0] hist1[$];
   logic [3:0] hist4[$];

   input_output #(.WIDTH(1), .SYNC_STAGES(0)) dut1 (
      .clk   (clk),
      .reset (reset),
      .in    (in1),
      .out   (out1)
   );

   input_output #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk   (clk),
      .reset (reset),
      .in    (in4),
      .out   (out4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pulse appears LAT edges after the edge that saw a 0->1 step in the sampled input.
   function automatic logic [3:0] model(input logic [3:0] h[$], input int lat);
      int         n;
      logic [3:0] cur;
      logic [3:0] prv;
      n   = h.size();
      cur = 4'b0;
      prv = 4'b0;
      if (n - 1 - lat >= 0) cur = h[n-1-lat];
      if (n - 2 - lat >= 0) prv = h[n-2-lat];
      return cur & ~prv;
   endfunction

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic i1, input logic [3:0] i4);
      logic [3:0] e1;
      logic [3:0] e4;
      in1 = i1;
      in4 = i4;
      @(posedge clk);
      #1;
      hist1.push_back({3'b000, i1});
      hist4.push_back(i4);
      e1 = model(hist1, 0);
      e4 = model(hist4, 2);
      chk("model_w1", {3'b000, out1}, {3'b000, e1[0]});
      chk("model_w4", out4, e4);
   endtask

   // Asserts reset between edges, checks the immediate clear, holds, then releases.
   task automatic do_reset(input int cycles);
      reset = 1'b0;
      #1;
      hist1.delete();
      hist4.delete();
      chk("async_clr_w1", {3'b000, out1}, 4'b0);
      chk("async_clr_w4", out4, 4'b0);
      repeat (cycles) begin
         @(posedge clk);
         #1;
         chk("in_reset_w1", {3'b000, out1}, 4'b0);
         chk("in_reset_w4", out4, 4'b0);
      end
      reset = 1'b1;
   endtask

   initial begin
      logic [4:0] pat;
      vectors     = 0;
      miscompares = 0;
      reset       = 1'b1;
      in1         = 1'b0;
      in4         = 4'b0;
      #2;

      do_reset(2);
      repeat (4) begin
         step(1'b0, 4'b0);
         chk("idle", {3'b000, out1}, 4'b0);
      end

      // Press and hold, release, re-press: 0,0,0,0,1,0,0,0 twice.
      repeat (2) begin
         for (int k = 0; k < 8; k++) begin
            step(k >= 4, 4'b0);
            chk("hold_seq", {3'b000, out1}, {3'b000, (k == 4)});
         end
      end

      step(1'b0, 4'b0);
      pat = 5'b10101;
      for (int k = 4; k >= 0; k--) begin
         step(pat[k], 4'b0);
         chk("toggle", {3'b000, out1}, {3'b000, pat[k]});
      end
      step(1'b0, 4'b0);
      chk("single_lo", {3'b000, out1}, 4'b0);
      step(1'b1, 4'b0);
      chk("single_hi", {3'b000, out1}, 4'b1);
      step(1'b0, 4'b0);
      chk("single_end", {3'b000, out1}, 4'b0);

      // Input held high across reset counts as a fresh press.
      in1 = 1'b1;
      in4 = 4'hF;
      do_reset(2);
      step(1'b1, 4'hF);
      chk("held_rst_pulse", {3'b000, out1}, 4'b1);
      step(1'b1, 4'hF);
      chk("held_rst_once", {3'b000, out1}, 4'b0);
      step(1'b1, 4'hF);
      chk("held_rst_w4", out4, 4'hF);
      step(1'b1, 4'hF);
      chk("held_rst_w4_end", out4, 4'h0);

      // Reset while the pulse is high drops it at once.
      step(1'b0, 4'h0);
      step(1'b1, 4'h0);
      chk("pre_midrst", {3'b000, out1}, 4'b1);
      in1 = 1'b0;
      do_reset(1);
      repeat (3) begin
         step(1'b0, 4'h0);
         chk("post_midrst", {3'b000, out1}, 4'b0);
      end

      // Two-stage synchronised multi-channel presses.
      step(1'b0, 4'b0101);
      step(1'b0, 4'b1111);
      chk("sync_lat1", out4, 4'b0000);
      step(1'b0, 4'b1111);
      chk("sync_0101", out4, 4'b0101);
      step(1'b0, 4'b1111);
      chk("sync_1010", out4, 4'b1010);
      step(1'b0, 4'b1111);
      chk("sync_width", out4, 4'b0000);

      for (int k = 0; k < 300; k++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         if (k == 150) begin
            do_reset(1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
